data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have the following ports (name direction width meaning), clock and reset first:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A (CPU load/store) request.
- a_we  in  1  port A op: 1 = write, 0 = read.
- a_addr  in  8  port A word address.
- a_wdata  in  32  port A write data.
- a_gnt  out  1  port A grant.
- a_done  out  1  port A completion pulse.
- a_rdata  out  32  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: same as port A, for port B (DMA/debug).
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  8  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; registered by the memory on the posedge where mem_read=1.
- busy  out  1  high whenever state != IDLE.
REQ-002 Reset SHALL be synchronous and active-high on rst, sampled only on posedge clk.
REQ-003 There SHALL be no parameters; the address width is fixed at 8 and the data width at 32.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-005 IDLE SHALL behave as follows:
- If any req is high, exactly one x_gnt SHALL be asserted combinationally in that cycle.
- {x_we, x_addr, x_wdata} and the owner SHALL be latched on the edge.
- The next state SHALL be ACCESS.
- With no req, the FSM SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin:
- If only one port requests, that port SHALL win.
- If both request, the port not granted most recently SHALL win.
- The last-grant pointer SHALL update only on a grant.
REQ-007 ACCESS SHALL last exactly one cycle:
- mem_addr and mem_wdata SHALL be driven from the latched values.
- mem_read SHALL equal ~latched_we and mem_write SHALL equal latched_we.
- The next state SHALL be RESP.
REQ-008 RESP SHALL last exactly one cycle:
- Strobes SHALL be low.
- On a read, the owner's x_rdata register SHALL load mem_rdata on the edge.
- The owner's x_done SHALL be registered high for the following cycle.
- The next state SHALL be IDLE.
REQ-009 Latency SHALL be fixed: grant at cycle N, strobe at N+1, x_done and valid x_rdata at N+3; a write also pulses x_done at N+3.
REQ-010 x_done SHALL be a single-cycle pulse; a new grant MAY occur in the same cycle as the previous x_done.
REQ-011 x_rdata SHALL hold its value until that port's next read completes; writes SHALL NOT modify x_rdata.
REQ-012 Requesters SHALL hold req and command until x_gnt; the block SHALL sample the command only in the grant cycle, and changes to it after the grant SHALL have no effect.
REQ-013 mem_read and mem_write SHALL never both be high.
REQ-014 Both strobes SHALL be low in IDLE and RESP.
REQ-015 a_gnt and b_gnt SHALL never both be high, and SHALL be low outside IDLE.
REQ-016 A req arriving while the FSM is in ACCESS or RESP SHALL be ignored until IDLE.
REQ-017 Sustained dual requests SHALL alternate A, B, A, B…, with one operation per 3 cycles.

Reset
REQ-018 When rst is high on a posedge, the block SHALL enter IDLE regardless of the current state.
REQ-019 Reset SHALL clear all outputs to 0: gnt, done, strobes, mem_addr, mem_wdata, both x_rdata and busy.
REQ-020 Reset SHALL set the round-robin pointer so that A wins the first tie.
REQ-021 While rst is high, no grant SHALL be issued.
REQ-022 An operation in flight SHALL be abandoned with no x_done; a write already strobed in ACCESS before the reset edge is not rolled back.

Verification
REQ-023 Single read: preload mem[0x10]=0xDEADBEEF; a_req=1, a_we=0, a_addr=0x10 at cycle 0 -> a_gnt at cycle 0, mem_read at cycle 1, a_done=1 and a_rdata=0xDEADBEEF at cycle 3.
REQ-024 Write then read: b writes 0x12345678 to 0x20, then b reads 0x20 -> mem_write=1 for exactly one cycle; the read returns b_rdata=0x12345678; a_rdata is unchanged.
REQ-025 Contention: a_req and b_req both held continuously from reset -> grant order A, B, A, B with 3-cycle spacing; gnt is never double; strobes are never simultaneous.
REQ-026 Reset mid-op: rst asserted during ACCESS of an A read -> next cycle IDLE, all outputs 0, no a_done; a subsequent tie is granted to A.
REQ-027 Late command change: a_addr changes in the cycle after a_gnt -> mem_addr carries the grant-cycle address.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port round-robin arbiter in front of a single-port data memory.
module data_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [7:0]  a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [7:0]  b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic [31:0] b_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic owner, last, lat_we;
  logic [7:0] lat_addr;
  logic [31:0] lat_wdata;
  // last=1 means B was granted most recently, so A wins the next tie
  always_comb begin
    a_gnt = (state == IDLE) && !rst && a_req && (!b_req || last);
    b_gnt = (state == IDLE) && !rst && b_req && (!a_req || !last);
    state_nx = state == IDLE ? ((a_req || b_req) ? ACCESS : IDLE) :
               state == ACCESS ? RESP : IDLE;
    mem_read = (state == ACCESS) && !lat_we;
    mem_write = (state == ACCESS) && lat_we;
    mem_addr = lat_addr;
    mem_wdata = lat_wdata;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      owner <= 1'b0;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      state <= state_nx;
      a_done <= (state == RESP) && !owner;
      b_done <= (state == RESP) && owner;
      if (a_gnt || b_gnt) begin
        owner <= b_gnt;
        last <= b_gnt;
        lat_we <= b_gnt ? b_we : a_we;
        lat_addr <= b_gnt ? b_addr : a_addr;
        lat_wdata <= b_gnt ? b_wdata : a_wdata;
      end
      if (state == RESP && !lat_we && !owner) a_rdata <= mem_rdata;
      if (state == RESP && !lat_we && owner) b_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of latency, round-robin order and reset behaviour.
module tb_data_mem_arbiter;
  logic clk = 0, rst = 1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [7:0] a_addr = 0, b_addr = 0;
  logic [31:0] a_wdata = 0, b_wdata = 0;
  logic a_gnt, a_done, b_gnt, b_done, mem_read, mem_write, busy;
  logic [31:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [7:0] mem_addr;
  logic [31:0] mem [256];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (rst) mem[8'h10] <= 32'hDEADBEEF;
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_read ? mem[mem_addr] : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // one transaction on port p; the command is scrambled right after the grant
  task automatic op(input bit p, input bit we, input logic [7:0] addr,
                    input logic [31:0] wd, input logic [31:0] exp_rd);
    logic [31:0] prev;
    @(negedge clk);
    prev = p ? b_rdata : a_rdata;
    if (p) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    #1;
    chk("gnt_own", p ? b_gnt : a_gnt, 1);
    chk("gnt_other", p ? a_gnt : b_gnt, 0);
    chk("idle_strobe", {mem_read, mem_write}, 0);
    @(negedge clk);
    if (p) begin b_req = 0; b_we = ~we; b_addr = ~addr; b_wdata = ~wd; end
    else begin a_req = 0; a_we = ~we; a_addr = ~addr; a_wdata = ~wd; end
    #1;
    chk("acc_read", mem_read, !we);
    chk("acc_write", mem_write, we);
    chk("acc_addr", mem_addr, addr);
    if (we) chk("acc_wdata", mem_wdata, wd);
    chk("acc_nognt", {a_gnt, b_gnt}, 0);
    chk("acc_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("resp_strobe", {mem_read, mem_write}, 0);
    chk("resp_done", {a_done, b_done}, 0);
    @(negedge clk);
    #1;
    chk("done", {a_done, b_done}, p ? 2'b01 : 2'b10);
    chk("rdata", p ? b_rdata : a_rdata, we ? prev : exp_rd);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {a_gnt, b_gnt, a_done, b_done, mem_read, mem_write}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ardata", a_rdata, 0);
    chk("rst_brdata", b_rdata, 0);
    rst = 0;
    op(0, 0, 8'h10, 32'h0, 32'hDEADBEEF);
    op(1, 1, 8'h20, 32'h12345678, 32'h0);
    op(1, 0, 8'h20, 32'h0, 32'h12345678);
    chk("a_rdata_kept", a_rdata, 32'hDEADBEEF);
    // sustained contention from reset
    @(negedge clk);
    rst = 1;
    a_req = 1; a_we = 0; a_addr = 8'h10;
    b_req = 1; b_we = 0; b_addr = 8'h20;
    #1;
    chk("rst_nognt", {a_gnt, b_gnt}, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      #1;
      chk("rr_a", a_gnt, i % 6 == 0);
      chk("rr_b", b_gnt, i % 6 == 3);
      chk("rr_strobe_excl", mem_read & mem_write, 0);
      chk("rr_a_done", a_done, i % 6 == 3);
      chk("rr_b_done", b_done, i > 0 && i % 6 == 0);
      if (i == 3) chk("rr_a_rdata", a_rdata, 32'hDEADBEEF);
      if (i == 6) chk("rr_b_rdata", b_rdata, 32'h12345678);
      @(negedge clk);
    end
    a_req = 0; b_req = 0;
    repeat (3) @(negedge clk);
    // reset during ACCESS of an A read, just after an A grant
    a_req = 1; a_we = 0; a_addr = 8'h10;
    #1;
    chk("mid_gnt", a_gnt, 1);
    @(negedge clk);
    a_req = 0;
    rst = 1;
    #1;
    chk("mid_acc", mem_read, 1);
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_outs", {a_done, b_done, mem_read, mem_write}, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_rdata", a_rdata, 0);
    @(negedge clk);
    #1;
    chk("mid_nodone", a_done, 0);
    a_req = 1; b_req = 1;
    #1;
    chk("mid_tie_a", a_gnt, 1);
    chk("mid_tie_b", b_gnt, 0);
    @(negedge clk);
    a_req = 0; b_req = 0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
